// File: rtl/mem_arbiter_if.sv
// Bundles the CPU port, DMA port and RAM port of the memory arbiter.
// Latency: none, wiring only.
// Backpressure: none here; requesters hold *_req until their *_ack pulse.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    // CPU requester
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;

    // DMA / debug loader requester
    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic [DATA_WIDTH-1:0] dma_rdata;
    logic                  dma_ack;

    // Shared RAM port and status
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ce;
    logic                  mem_we;
    logic                  grant;
    logic                  busy;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_addr, mem_wdata, mem_ce, mem_we, grant, busy,
        input  mem_rdata
    );

    // Requester / RAM model side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_wdata, mem_ce, mem_we, grant, busy,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the CPU and the DMA loader, round-robin when both request.
// Latency: req sampled at edge N -> mem_ce high cycles N+1..N+C -> one-cycle ack in N+C+1.
// Backpressure: requesters hold req until ack; port inputs are ignored outside IDLE.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  grant_q,     grant_d;     // owner of current/last access, 1 = DMA
    logic                  rr_q,        rr_d;        // port that wins the next tie, 1 = DMA
    logic                  we_q,        we_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    // Next-state: grant selection in IDLE, wait-state countdown in ACCESS, ack in DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    // A lone requester wins outright; a tie goes to the RR pointer.
                    if (bus.cpu_req && bus.dma_req) begin
                        grant_d = rr_q;
                    end else begin
                        grant_d = bus.dma_req;
                    end
                    rr_d    = ~grant_d;
                    we_d    = grant_d ? bus.dma_we    : bus.cpu_we;
                    addr_d  = grant_d ? bus.dma_addr  : bus.cpu_addr;
                    wdata_d = grant_d ? bus.dma_wdata : bus.cpu_wdata;
                    cnt_d   = we_d ? CNT_W'(WRITE_CYCLES - 1) : CNT_W'(READ_CYCLES - 1);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // Last wait state: RAM data is valid now, capture for the owner only.
                    if (!we_q) begin
                        if (grant_q) begin
                            dma_rdata_d = bus.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight without an ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            rr_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free per cycle.
    assign bus.mem_ce    = (state_q == ST_ACCESS);
    assign bus.mem_we    = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = (state_q == ST_DONE) && !grant_q;
    assign bus.dma_ack   = (state_q == ST_DONE) &&  grant_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a RAM model and an ack-driven scoreboard.
// Latency: checks the N+1..N+C chip-enable window and the N+C+1 ack cycle.
// Backpressure: exercises held, dropped and tied requests plus reset mid-access.
module tb_mem_arbiter;
    localparam int CYC = 2;

    typedef struct packed {
        logic       port;   // 1 = DMA
        logic       rd;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (8),
        .READ_CYCLES (CYC),
        .WRITE_CYCLES(CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] ram    [0:65535];
    logic [7:0] shadow [0:65535];
    exp_t       sb_q [$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         cpu_acks = 0;
    int         dma_acks = 0;
    logic [7:0] cpu_last = 8'h00;
    logic [7:0] dma_last = 8'h00;

    // Asynchronous-read RAM, written on the clock while enabled for write
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_ce && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ack monitor: pops the scoreboard on every completion
    always @(negedge clk) begin
        if (bus.mem_we) check("we_implies_ce", 32'(bus.mem_ce), 32'd1);
        if (bus.cpu_ack || bus.dma_ack) begin
            if (bus.cpu_ack) cpu_acks++;
            if (bus.dma_ack) dma_acks++;
            check("ack_exclusive", 32'(bus.cpu_ack & bus.dma_ack), 32'd0);
            check("ack_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("ack_port", 32'(bus.dma_ack), 32'(mon_e.port));
                if (mon_e.rd)
                    check("ack_rdata", 32'(mon_e.port ? bus.dma_rdata : bus.cpu_rdata),
                          32'(mon_e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
    endtask

    task automatic drive(input logic port, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd);
        if (port) begin
            bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wd;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        end
    endtask

    // Push the expected completion and track what each port's rdata must hold afterwards
    task automatic expect_acc(input logic port, input logic we, input logic [15:0] addr,
                              input logic [7:0] wd);
        if (we) shadow[addr] = wd;
        sb_q.push_back('{port: port, rd: !we, data: shadow[addr]});
        if (!we && port)  dma_last = shadow[addr];
        if (!we && !port) cpu_last = shadow[addr];
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
        cpu_last = 8'h00;
        dma_last = 8'h00;
    endtask

    // One uncontested access, req held until ack, full cycle-by-cycle checks
    task automatic access(input logic port, input logic we, input logic [15:0] addr,
                          input logic [7:0] wd);
        expect_acc(port, we, addr, wd);
        drive(port, we, addr, wd);
        step();
        for (int i = 0; i < CYC; i++) begin
            check("acc_ce", 32'(bus.mem_ce), 32'd1);
            check("acc_we", 32'(bus.mem_we), 32'(we));
            check("acc_addr", 32'(bus.mem_addr), 32'(addr));
            if (we) check("acc_wdata", 32'(bus.mem_wdata), 32'(wd));
            check("acc_grant", 32'(bus.grant), 32'(port));
            check("acc_busy", 32'(bus.busy), 32'd1);
            check("acc_no_ack", 32'(bus.cpu_ack | bus.dma_ack), 32'd0);
            step();
        end
        check("done_ce", 32'(bus.mem_ce | bus.mem_we), 32'd0);
        check("done_own_ack", 32'(port ? bus.dma_ack : bus.cpu_ack), 32'd1);
        check("done_other_ack", 32'(port ? bus.cpu_ack : bus.dma_ack), 32'd0);
        drop_reqs();
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ack", 32'(bus.cpu_ack | bus.dma_ack), 32'd0);
        check("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'(cpu_last));
        check("dma_rdata_hold", 32'(bus.dma_rdata), 32'(dma_last));
    endtask

    // Both ports request together; CPU must win, then both drop mid-access
    task automatic tie_expect_cpu(input string tag);
        expect_acc(1'b0, 1'b0, 16'h1234, 8'h00);
        drive(1'b0, 1'b0, 16'h1234, 8'h00);
        drive(1'b1, 1'b0, 16'h0020, 8'h00);
        step();
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'h1234);
        drop_reqs();
        for (int i = 0; i < 8 && !(bus.cpu_ack || bus.dma_ack); i++) step();
        check({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 32'd1);
        step();
        step();
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int last;
        int acks0;

        for (int i = 0; i < 65536; i++) begin
            ram[i]    = pat(16'(i));
            shadow[i] = pat(16'(i));
        end
        ram[16'h1234]    = 8'hA5;
        shadow[16'h1234] = 8'hA5;
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;

        // Reset held 3 cycles with both requests high
        bus.cpu_req = 1'b1;
        bus.dma_req = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ce", 32'(bus.mem_ce | bus.mem_we), 32'd0);
            check("rst_ack", 32'(bus.cpu_ack | bus.dma_ack), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_grant", 32'(bus.grant), 32'd0);
            check("rst_rdata", 32'({bus.cpu_rdata, bus.dma_rdata}), 32'd0);
        end
        drop_reqs();
        rst = 1'b0;
        step();

        // CPU read, write/readback, DMA accesses with non-owner rdata held
        access(1'b0, 1'b0, 16'h1234, 8'h00);
        access(1'b0, 1'b1, 16'h0042, 8'h5A);
        access(1'b0, 1'b0, 16'h0042, 8'h00);
        access(1'b1, 1'b0, 16'h1234, 8'h00);
        access(1'b1, 1'b1, 16'h0099, 8'h3C);
        access(1'b1, 1'b0, 16'h0099, 8'h00);

        // Continuous tie after reset: CPU, DMA, CPU, DMA with one idle cycle between
        do_reset(2);
        for (int k = 0; k < 2; k++) begin
            expect_acc(1'b0, 1'b0, 16'h0010, 8'h00);
            expect_acc(1'b1, 1'b0, 16'h0020, 8'h00);
        end
        drive(1'b0, 1'b0, 16'h0010, 8'h00);
        drive(1'b1, 1'b0, 16'h0020, 8'h00);
        n = 0;
        last = -1;
        for (int t = 0; t < 40 && n < 4; t++) begin
            step();
            if (bus.cpu_ack || bus.dma_ack) begin
                if (n > 0) check("tie_gap", 32'(t - last), 32'd4);
                check("tie_order", 32'(bus.grant), 32'(n % 2));
                last = t;
                n++;
                if (n == 4) drop_reqs();
            end else if (last >= 0 && t == last + 1) begin
                check("tie_turnaround", 32'(bus.busy), 32'd0);
            end
        end
        check("tie_count", 32'(n), 32'd4);
        step();
        check("tie_end_busy", 32'(bus.busy), 32'd0);

        // Reset during the 2nd ACCESS cycle of a DMA write
        acks0 = dma_acks;
        drive(1'b1, 1'b1, 16'h0077, 8'hEE);
        step();
        check("abort_ce1", 32'({bus.mem_ce, bus.mem_we, bus.grant}), 32'b111);
        step();
        check("abort_ce2", 32'(bus.mem_ce), 32'd1);
        drop_reqs();
        do_reset(1);
        check("abort_ce_low", 32'(bus.mem_ce | bus.mem_we), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        step();
        step();
        check("abort_no_ack", 32'(dma_acks - acks0), 32'd0);
        tie_expect_cpu("post_dma_abort");

        // Reset mid CPU access must also restore the tie pointer to CPU
        drive(1'b0, 1'b0, 16'h0020, 8'h00);
        step();
        drop_reqs();
        do_reset(1);
        tie_expect_cpu("post_cpu_abort");

        // One-cycle CPU pulse, address changed mid-access
        acks0 = cpu_acks;
        expect_acc(1'b0, 1'b0, 16'h1234, 8'h00);
        drive(1'b0, 1'b0, 16'h1234, 8'h00);
        step();
        bus.cpu_req = 1'b0;
        bus.cpu_addr = 16'h0042;
        check("pulse_addr1", 32'(bus.mem_addr), 32'h1234);
        step();
        check("pulse_addr2", 32'(bus.mem_addr), 32'h1234);
        check("pulse_ce2", 32'(bus.mem_ce), 32'd1);
        step();
        check("pulse_ack", 32'(bus.cpu_ack), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("pulse_idle", 32'({bus.busy, bus.mem_ce}), 32'd0);
        end
        check("pulse_ack_once", 32'(cpu_acks - acks0), 32'd1);
        check("pulse_addr_hold", 32'(bus.mem_addr), 32'h1234);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
